// File: rtl/gray_rr_sched.sv
// Round-robin burst scheduler sharing one gray-code counter among NREQ requesters.
// Optional request-drop abort (adds port abrt) is enabled with `define GRAY_SCHED_ABORT_EN.
//
// state  | meaning
// IDLE   | arbitrate among pending requests, counter held
// RUN    | winner granted, counter advances once per cycle
// DONE   | one-cycle completion pulse, counter held
module gray_rr_sched #(
    parameter int NREQ  = 4,
    parameter int CBITS = 8,
    parameter int LBITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*LBITS-1:0]     len,
    output logic [NREQ-1:0]           gnt,
    output logic                      busy,
    output logic [CBITS-1:0]          gray_out,
    output logic                      done,
`ifdef GRAY_SCHED_ABORT_EN
    output logic                      abrt,
`endif
    output logic [$clog2(NREQ)-1:0]   done_id
);

    localparam int IDW = $clog2(NREQ);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [CBITS-1:0] cnt;
    logic [CBITS-1:0] cnt_inc;
    logic [IDW-1:0]   id;
    logic [IDW-1:0]   last;
    logic [IDW-1:0]   pick;
    logic [LBITS-1:0] rem;
    logic             found;
`ifdef GRAY_SCHED_ABORT_EN
    logic             abort_q;
`endif

    assign cnt_inc = cnt + CBITS'(1);

    // Search upward from the requester after the last winner, wrapping around.
    always_comb begin
        int j;
        found = 1'b0;
        pick  = '0;
        j     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(last) + k) % NREQ;
            if (!found && req[j]) begin
                found = 1'b1;
                pick  = IDW'(j);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            gray_out <= '0;
            id       <= '0;
            rem      <= '0;
            last     <= IDW'(NREQ - 1);
`ifdef GRAY_SCHED_ABORT_EN
            abort_q  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        id    <= pick;
                        rem   <= len[pick*LBITS +: LBITS];
                        last  <= pick;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    cnt      <= cnt_inc;
                    gray_out <= cnt_inc ^ (cnt_inc >> 1);
`ifdef GRAY_SCHED_ABORT_EN
                    if (!req[id]) begin
                        state   <= S_DONE;
                        abort_q <= 1'b1;
                    end else if (rem == '0) begin
                        state <= S_DONE;
                    end else begin
                        rem <= rem - LBITS'(1);
                    end
`else
                    if (rem == '0) state <= S_DONE;
                    else           rem   <= rem - LBITS'(1);
`endif
                end
                S_DONE: begin
                    state <= S_IDLE;
`ifdef GRAY_SCHED_ABORT_EN
                    abort_q <= 1'b0;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign gnt     = (state == S_RUN) ? (NREQ'(1) << id) : '0;
    assign busy    = (state == S_RUN) || (state == S_DONE);
    assign done    = (state == S_DONE);
    assign done_id = done ? id : '0;
`ifdef GRAY_SCHED_ABORT_EN
    assign abrt    = done && abort_q;
`endif

endmodule
